// File: rtl/pipe_mem_pkg.sv
// Shared types and exception codes for the memory-access stage.
// Also holds the helper that computes the reported exception PC.
package pipe_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  // A faulting delay-slot instruction reports the PC of its branch
  function automatic logic [31:0] exc_pc(input logic isbr, input logic [31:0] pc);
    return isbr ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/pipe_mem_stage_fpu_if.sv
// Data-memory request/acknowledge bus between the M stage and the data memory.
interface pipe_mem_stage_fpu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/pipe_m2w_reg_fpu.sv
// M/W pipeline register: loads when enabled, holds otherwise; a bubble
// clears the write-back controls and the load data.
module pipe_m2w_reg_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwfpr,
  input  logic [31:0] mmo,
  input  logic [31:0] malu,
  input  logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic        wwfpr,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);
  logic        wwreg_q, wwreg_d;
  logic        wm2reg_q, wm2reg_d;
  logic        wwfpr_q, wwfpr_d;
  logic [31:0] wmo_q, wmo_d;
  logic [31:0] walu_q, walu_d;
  logic [4:0]  wrn_q, wrn_d;

  always_comb begin
    wwreg_d  = wwreg_q;
    wm2reg_d = wm2reg_q;
    wwfpr_d  = wwfpr_q;
    wmo_d    = wmo_q;
    walu_d   = walu_q;
    wrn_d    = wrn_q;
    if (en) begin
      wwreg_d  = mwreg  & ~bubble;
      wm2reg_d = mm2reg & ~bubble;
      wwfpr_d  = mwfpr  & ~bubble;
      wmo_d    = bubble ? 32'd0 : mmo;
      walu_d   = malu;
      wrn_d    = mrn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wwfpr_q  <= 1'b0;
      wmo_q    <= 32'd0;
      walu_q   <= 32'd0;
      wrn_q    <= 5'd0;
    end else begin
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wwfpr_q  <= wwfpr_d;
      wmo_q    <= wmo_d;
      walu_q   <= walu_d;
      wrn_q    <= wrn_d;
    end
  end

  assign wwreg  = wwreg_q;
  assign wm2reg = wm2reg_q;
  assign wwfpr  = wwfpr_q;
  assign wmo    = wmo_q;
  assign walu   = walu_q;
  assign wrn    = wrn_q;
endmodule

// File: rtl/pipe_mem_stage_fpu.sv
// Memory-access stage: data-memory transaction FSM with bus timeout,
// alignment/bus-error exception reporting and the M/W pipeline register.
module pipe_mem_stage_fpu
  import pipe_mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic        misbr,
  input  logic        mwfpr,
  input  logic [31:0] malu,
  input  logic [31:0] mdb,
  input  logic [31:0] pcm,
  input  logic [4:0]  mrn,
  pipe_mem_stage_fpu_if.master dm,
  output logic        mem_stall,
  output logic        mem_exc,
  output logic [4:0]  mem_cause,
  output logic [31:0] mem_epc,
  output logic        mem_bd,
  output logic        wwreg,
  output logic        wm2reg,
  output logic        wwfpr,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [31:0] ldbuf_q, ldbuf_d;
  logic        mem_exc_q, mem_exc_d;
  logic [4:0]  mem_cause_q, mem_cause_d;
  logic [31:0] mem_epc_q, mem_epc_d;
  logic        mem_bd_q, mem_bd_d;

  logic        memop, misal, timeout, stall, bubble;
  logic [31:0] mo;

  assign memop   = mm2reg | mwmem;
  assign misal   = memop & (malu[1:0] != 2'b00);
  // An ack in the final allowed cycle takes priority over the timeout
  assign timeout = (state_q == BUSY) & ~dm.dm_ack & (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    ldbuf_d     = ldbuf_q;
    mem_exc_d   = 1'b0;
    mem_cause_d = mem_cause_q;
    mem_epc_d   = mem_epc_q;
    mem_bd_d    = mem_bd_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    mo          = 32'd0;
    case (state_q)
      IDLE: begin
        if (misal) begin
          bubble      = 1'b1;
          mem_exc_d   = 1'b1;
          mem_cause_d = mm2reg ? EXC_ADEL : EXC_ADES;
          mem_epc_d   = exc_pc(misbr, pcm);
          mem_bd_d    = misbr;
        end else if (memop) begin
          stall      = 1'b1;
          dm_req_d   = 1'b1;
          dm_we_d    = mwmem;
          dm_addr_d  = {malu[31:2], 2'b00};
          dm_wdata_d = mdb;
          wait_cnt_d = 8'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (dm.dm_ack) begin
          stall    = 1'b1;
          ldbuf_d  = dm.dm_rdata;
          dm_req_d = 1'b0;
          state_d  = DONE;
        end else if (timeout) begin
          bubble      = 1'b1;
          dm_req_d    = 1'b0;
          state_d     = IDLE;
          mem_exc_d   = 1'b1;
          mem_cause_d = EXC_DBE;
          mem_epc_d   = exc_pc(misbr, pcm);
          mem_bd_d    = misbr;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      DONE: begin
        mo      = mm2reg ? ldbuf_q : 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_wdata_q  <= 32'd0;
      ldbuf_q     <= 32'd0;
      mem_exc_q   <= 1'b0;
      mem_cause_q <= 5'd0;
      mem_epc_q   <= 32'd0;
      mem_bd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      ldbuf_q     <= ldbuf_d;
      mem_exc_q   <= mem_exc_d;
      mem_cause_q <= mem_cause_d;
      mem_epc_q   <= mem_epc_d;
      mem_bd_q    <= mem_bd_d;
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;
  assign mem_stall   = stall;
  assign mem_exc     = mem_exc_q;
  assign mem_cause   = mem_cause_q;
  assign mem_epc     = mem_epc_q;
  assign mem_bd      = mem_bd_q;

  pipe_m2w_reg_fpu u_m2w (
    .clk    (clk),
    .rst    (rst),
    .en     (~stall),
    .bubble (bubble),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mwfpr  (mwfpr),
    .mmo    (mo),
    .malu   (malu),
    .mrn    (mrn),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wwfpr  (wwfpr),
    .wmo    (wmo),
    .walu   (walu),
    .wrn    (wrn)
  );
endmodule

// File: tb/tb_pipe_mem_stage_fpu.sv
// Self-checking bench for pipe_mem_stage_fpu: scoreboarded W-stage results,
// transaction timing, exceptions, timeout and reset abort.
module tb_pipe_mem_stage_fpu;

  typedef struct packed {
    logic        wwreg;
    logic        wm2reg;
    logic        wwfpr;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
  } w_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mwreg, mm2reg, mwmem, misbr, mwfpr;
  logic [31:0] malu, mdb, pcm;
  logic [4:0]  mrn;
  logic        mem_stall, mem_exc, mem_bd;
  logic [4:0]  mem_cause, wrn;
  logic [31:0] mem_epc, wmo, walu;
  logic        wwreg, wm2reg, wwfpr;

  pipe_mem_stage_fpu_if dm_if ();

  pipe_mem_stage_fpu #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .misbr(misbr), .mwfpr(mwfpr),
    .malu(malu), .mdb(mdb), .pcm(pcm), .mrn(mrn),
    .dm(dm_if),
    .mem_stall(mem_stall), .mem_exc(mem_exc), .mem_cause(mem_cause),
    .mem_epc(mem_epc), .mem_bd(mem_bd),
    .wwreg(wwreg), .wm2reg(wm2reg), .wwfpr(wwfpr),
    .wmo(wmo), .walu(walu), .wrn(wrn)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  w_exp_t sb[$];
  int     m_cycles, req_cycles, stall_cycles;
  logic        last_we;
  logic [31:0] last_addr, last_wdata;

  task automatic clear_m();
    mwreg = 0; mm2reg = 0; mwmem = 0; misbr = 0; mwfpr = 0;
    malu = 32'd0; mdb = 32'd0; pcm = 32'd0; mrn = 5'd0;
  endtask

  // Present one instruction in M (at posedge+1), play the memory with an ack
  // on BUSY cycle ack_at (0 = never), and check W after the M/W load.
  task automatic run_op(input string name, input logic wreg_i, m2reg_i, wmem_i, isbr_i, wfpr_i,
                        input logic [31:0] alu_i, db_i, pc_i, input logic [4:0] rn_i,
                        input int ack_at, input logic [31:0] rdata_i, input w_exp_t exp_w);
    bit     done = 0;
    w_exp_t obs, e;
    sb.push_back(exp_w);
    mwreg = wreg_i; mm2reg = m2reg_i; mwmem = wmem_i; misbr = isbr_i; mwfpr = wfpr_i;
    malu = alu_i; mdb = db_i; pcm = pc_i; mrn = rn_i;
    m_cycles = 0; req_cycles = 0; stall_cycles = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      dm_if.dm_ack   = 1'b0;
      dm_if.dm_rdata = 32'hBAD0_BAD0;
      if (dm_if.dm_req) begin
        req_cycles++;
        last_we = dm_if.dm_we; last_addr = dm_if.dm_addr; last_wdata = dm_if.dm_wdata;
        if (req_cycles == ack_at) begin
          dm_if.dm_ack = 1'b1; dm_if.dm_rdata = rdata_i;
        end
      end
      #1;
      m_cycles++;
      if (mem_stall) stall_cycles++; else done = 1;
      @(posedge clk); #1;
    end
    dm_if.dm_ack = 1'b0;
    clear_m();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s budget: instruction still stalled after %0d cycles, required release", name, m_cycles);
    end
    e = sb.pop_front();
    obs = '{wwreg, wm2reg, wwfpr, wmo, walu, wrn};
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s w_regs: got wreg=%b m2reg=%b wfpr=%b wmo=%h walu=%h wrn=%0d, required wreg=%b m2reg=%b wfpr=%b wmo=%h walu=%h wrn=%0d",
               name, obs.wwreg, obs.wm2reg, obs.wwfpr, obs.wmo, obs.walu, obs.wrn,
               e.wwreg, e.wm2reg, e.wwfpr, e.wmo, e.walu, e.wrn);
    end
    $display("[TB] %s: m_cycles=%0d req_cycles=%0d stall_cycles=%0d wmo=%h walu=%h",
             name, m_cycles, req_cycles, stall_cycles, wmo, walu);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_m();
    dm_if.dm_ack = 1'b0; dm_if.dm_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dm_if.dm_req, dm_if.dm_we, dm_if.dm_addr, dm_if.dm_wdata, mem_exc, mem_bd, mem_cause, mem_epc,
         wwreg, wm2reg, wwfpr, wmo, walu, wrn, mem_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h exc=%b bd=%b cause=%0d epc=%h w=%b%b%b wmo=%h walu=%h wrn=%0d stall=%b, required all 0",
               dm_if.dm_req, dm_if.dm_we, dm_if.dm_addr, dm_if.dm_wdata, mem_exc, mem_bd, mem_cause, mem_epc,
               wwreg, wm2reg, wwfpr, wmo, walu, wrn, mem_stall);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    run_op("alu", 1, 0, 0, 0, 0, 32'h1234, 32'd0, 32'h80, 5'd8, 0, 32'd0,
           '{1'b1, 1'b0, 1'b0, 32'd0, 32'h1234, 5'd8});
    n_tests++;
    if (m_cycles != 1 || stall_cycles != 0 || req_cycles != 0) begin
      n_fail++;
      $display("FAIL alu_timing: m=%0d stall=%0d req=%0d, required 1/0/0", m_cycles, stall_cycles, req_cycles);
    end
    n_tests++;
    if (mem_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_no_exc: mem_exc=%b, required 0", mem_exc);
    end
  endtask

  task automatic test_load();
    run_op("load", 1, 1, 0, 0, 0, 32'h100, 32'd0, 32'h84, 5'd9, 3, 32'hDEADBEEF,
           '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h100, 5'd9});
    n_tests++;
    if (req_cycles != 3 || stall_cycles != 4 || m_cycles != 5) begin
      n_fail++;
      $display("FAIL load_timing: req=%0d stall=%0d m=%0d, required 3/4/5", req_cycles, stall_cycles, m_cycles);
    end
    n_tests++;
    if (last_addr !== 32'h100 || last_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_bus: addr=%h we=%b, required 00000100/0", last_addr, last_we);
    end
  endtask

  task automatic test_store();
    run_op("store", 0, 0, 1, 0, 0, 32'h200, 32'hCAFE, 32'h88, 5'd0, 1, 32'h5555_5555,
           '{1'b0, 1'b0, 1'b0, 32'd0, 32'h200, 5'd0});
    n_tests++;
    if (last_we !== 1'b1 || last_wdata !== 32'hCAFE || last_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL store_bus: we=%b wdata=%h addr=%h, required 1/0000cafe/00000200", last_we, last_wdata, last_addr);
    end
    n_tests++;
    if (m_cycles != 3 || req_cycles != 1) begin
      n_fail++;
      $display("FAIL store_timing: m=%0d req=%0d, required 3/1", m_cycles, req_cycles);
    end
  endtask

  task automatic test_misaligned();
    run_op("adel", 1, 1, 0, 1, 0, 32'h102, 32'd0, 32'h400, 5'd3, 1, 32'h1111_1111,
           '{1'b0, 1'b0, 1'b0, 32'd0, 32'h102, 5'd3});
    n_tests++;
    if (req_cycles != 0 || m_cycles != 1) begin
      n_fail++;
      $display("FAIL adel_timing: req=%0d m=%0d, required 0/1", req_cycles, m_cycles);
    end
    n_tests++;
    if (mem_exc !== 1'b1 || mem_cause !== 5'd4 || mem_epc !== 32'h3FC || mem_bd !== 1'b1) begin
      n_fail++;
      $display("FAIL adel_exc: exc=%b cause=%0d epc=%h bd=%b, required 1/4/000003fc/1", mem_exc, mem_cause, mem_epc, mem_bd);
    end
    run_op("ades", 0, 0, 1, 0, 0, 32'h203, 32'h77, 32'h600, 5'd0, 1, 32'd0,
           '{1'b0, 1'b0, 1'b0, 32'd0, 32'h203, 5'd0});
    n_tests++;
    if (mem_exc !== 1'b1 || mem_cause !== 5'd5 || mem_epc !== 32'h600 || mem_bd !== 1'b0) begin
      n_fail++;
      $display("FAIL ades_exc: exc=%b cause=%0d epc=%h bd=%b, required 1/5/00000600/0", mem_exc, mem_cause, mem_epc, mem_bd);
    end
  endtask

  task automatic test_timeout();
    run_op("dbe", 1, 1, 0, 0, 0, 32'h300, 32'd0, 32'h500, 5'd4, 0, 32'd0,
           '{1'b0, 1'b0, 1'b0, 32'd0, 32'h300, 5'd4});
    n_tests++;
    if (req_cycles != 4 || stall_cycles != 4 || m_cycles != 5) begin
      n_fail++;
      $display("FAIL dbe_timing: req=%0d stall=%0d m=%0d, required 4/4/5", req_cycles, stall_cycles, m_cycles);
    end
    n_tests++;
    if (mem_exc !== 1'b1 || mem_cause !== 5'd7 || mem_epc !== 32'h500 || mem_bd !== 1'b0) begin
      n_fail++;
      $display("FAIL dbe_exc: exc=%b cause=%0d epc=%h bd=%b, required 1/7/00000500/0", mem_exc, mem_cause, mem_epc, mem_bd);
    end
    // A late ack with a NOP in M must change nothing
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hFFFF_0000;
    #1;
    n_tests++;
    if (mem_stall !== 1'b0 || dm_if.dm_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack_bus: stall=%b req=%b, required 0/0", mem_stall, dm_if.dm_req);
    end
    @(posedge clk); #1;
    dm_if.dm_ack = 1'b0;
    n_tests++;
    if (mem_exc !== 1'b0 || mem_cause !== 5'd7 || wmo !== 32'd0 || wm2reg !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack_state: exc=%b cause=%0d wmo=%h wm2reg=%b, required 0/7/00000000/0", mem_exc, mem_cause, wmo, wm2reg);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_alu", 1, 0, 0, 0, 0, 32'hA5A5_0001, 32'd0, 32'h90, 5'd17, 0, 32'd0,
           '{1'b1, 1'b0, 1'b0, 32'd0, 32'hA5A5_0001, 5'd17});
    run_op("b2b_load", 1, 1, 0, 0, 0, 32'h44, 32'd0, 32'h94, 5'd18, 4, 32'h0BAD_F00D,
           '{1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h44, 5'd18});
    n_tests++;
    if (m_cycles != 6 || req_cycles != 4) begin
      n_fail++;
      $display("FAIL b2b_last_ack: m=%0d req=%0d, required 6/4", m_cycles, req_cycles);
    end
  endtask

  task automatic test_reset_busy();
    int busy_seen = 0;
    mwreg = 1; mm2reg = 1; malu = 32'h80; pcm = 32'hA0; mrn = 5'd5;
    dm_if.dm_ack = 1'b0;
    @(posedge clk); #1;
    if (dm_if.dm_req) busy_seen++;
    @(posedge clk); #1;
    if (dm_if.dm_req) busy_seen++;
    n_tests++;
    if (busy_seen != 2) begin
      n_fail++;
      $display("FAIL rst_busy_pre: req high %0d of 2 cycles, required 2", busy_seen);
    end
    rst = 1'b1; clear_m();
    @(posedge clk); #1;
    n_tests++;
    if (dm_if.dm_req !== 1'b0 || mem_stall !== 1'b0 ||
        {wwreg, wm2reg, wwfpr, wmo, walu, wrn} !== '0) begin
      n_fail++;
      $display("FAIL rst_busy_abort: req=%b stall=%b w=%b%b%b wmo=%h walu=%h wrn=%0d, required all 0",
               dm_if.dm_req, mem_stall, wwreg, wm2reg, wwfpr, wmo, walu, wrn);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("lwc1", 0, 1, 0, 0, 1, 32'h40, 32'd0, 32'hB0, 5'd2, 2, 32'h3F80_0000,
           '{1'b0, 1'b1, 1'b1, 32'h3F80_0000, 32'h40, 5'd2});
    n_tests++;
    if (m_cycles != 4) begin
      n_fail++;
      $display("FAIL lwc1_timing: m=%0d, required 4", m_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
